// File: rtl/mux_n_stream_if.sv
// mux_n_stream_if
// Bundles the N-channel operand streams and the merged output stream of
// mux_n_stream into one interface.
//   master : stream sources / sink side (drives iData, iValid, iMode, iSel, iReady)
//   slave  : the multiplexor (drives oReady, oData, oChan, oValid)
// Parameters must match the ones given to the mux_n_stream instance.
interface mux_n_stream_if #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_CH     = 4,
    parameter int SEL_WIDTH  = 2
);
    logic [NUM_CH*DATA_WIDTH-1:0] iData;
    logic [NUM_CH-1:0]            iValid;
    logic [NUM_CH-1:0]            oReady;
    logic                         iMode;
    logic [SEL_WIDTH-1:0]         iSel;
    logic [DATA_WIDTH-1:0]        oData;
    logic [SEL_WIDTH-1:0]         oChan;
    logic                         oValid;
    logic                         iReady;

    modport master (
        output iData, iValid, iMode, iSel, iReady,
        input  oReady, oData, oChan, oValid
    );

    modport slave (
        input  iData, iValid, iMode, iSel, iReady,
        output oReady, oData, oChan, oValid
    );
endinterface

// File: rtl/mux_n_stream.sv
// mux_n_stream
// Merges NUM_CH valid/ready operand streams into one output stream through a
// 2-entry registered buffer, feeding the shared FP adder/multiplier stage.
// Channel choice is either a fixed external select (iMode=0) or round-robin
// (iMode=1). Sustains one word per cycle while the sink keeps iReady high.
// Ports:
//   clk     rising-edge clock
//   resetn  asynchronous active-low reset
//   bus     mux_n_stream_if.slave
//             iData/iValid/oReady : per-channel input streams
//             iMode/iSel          : fixed vs round-robin, fixed-mode channel
//             oData/oChan/oValid  : head word of the buffer and its source
//             iReady              : sink accepts the head word
module mux_n_stream #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_CH     = 4,
    parameter int SEL_WIDTH  = 2
) (
    input  logic           clk,
    input  logic           resetn,
    mux_n_stream_if.slave  bus
);

    logic [1:0]            count_q, count_d;
    logic [SEL_WIDTH-1:0]  rr_ptr_q, rr_ptr_d;
    // slot0 is the head (drives oData/oChan directly), slot1 is the tail
    // entry used only when two words are held.
    logic [DATA_WIDTH-1:0] slot0_data_q, slot0_data_d;
    logic [SEL_WIDTH-1:0]  slot0_chan_q, slot0_chan_d;
    logic [DATA_WIDTH-1:0] slot1_data_q, slot1_data_d;
    logic [SEL_WIDTH-1:0]  slot1_chan_q, slot1_chan_d;

    logic                  grant_valid;
    logic [SEL_WIDTH-1:0]  grant_idx;
    logic [DATA_WIDTH-1:0] grant_data;
    int                    best_dist;
    logic                  space;
    logic                  accept;
    logic                  drain;

    // Round-robin picks the valid channel at the smallest wrapped distance
    // from rr_ptr, which is the first one found searching upward from it.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        best_dist   = NUM_CH;
        if (!bus.iMode) begin
            // out-of-range selects match no channel and so grant nothing
            for (int k = 0; k < NUM_CH; k++) begin
                if (int'(bus.iSel) == k && bus.iValid[k]) begin
                    grant_valid = 1'b1;
                    grant_idx   = SEL_WIDTH'(k);
                end
            end
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (bus.iValid[k] &&
                    ((k + NUM_CH - int'(rr_ptr_q)) % NUM_CH) < best_dist) begin
                    best_dist   = (k + NUM_CH - int'(rr_ptr_q)) % NUM_CH;
                    grant_valid = 1'b1;
                    grant_idx   = SEL_WIDTH'(k);
                end
            end
        end
    end

    always_comb begin
        grant_data = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (grant_idx == SEL_WIDTH'(k)) begin
                grant_data = bus.iData[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign space  = (count_q != 2'd2);
    assign accept = grant_valid && space;
    assign drain  = (count_q != 2'd0) && bus.iReady;

    // resetn gates oReady so no source sees a handshake during reset.
    always_comb begin
        bus.oReady = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            bus.oReady[k] = resetn && accept && (grant_idx == SEL_WIDTH'(k));
        end
    end

    always_comb begin
        count_d      = count_q;
        rr_ptr_d     = rr_ptr_q;
        slot0_data_d = slot0_data_q;
        slot0_chan_d = slot0_chan_q;
        slot1_data_d = slot1_data_q;
        slot1_chan_d = slot1_chan_q;

        if (accept && !drain) begin
            count_d = count_q + 2'd1;
        end else if (drain && !accept) begin
            count_d = count_q - 2'd1;
        end

        if (accept && bus.iMode) begin
            rr_ptr_d = SEL_WIDTH'((int'(grant_idx) + 1) % NUM_CH);
        end

        // The head is left untouched when the last word drains so oData/oChan
        // keep their final value while the buffer is empty.
        if (accept && (count_q == 2'd0 || (count_q == 2'd1 && drain))) begin
            slot0_data_d = grant_data;
            slot0_chan_d = grant_idx;
        end else if (accept && count_q == 2'd1) begin
            slot1_data_d = grant_data;
            slot1_chan_d = grant_idx;
        end else if (drain && count_q == 2'd2) begin
            slot0_data_d = slot1_data_q;
            slot0_chan_d = slot1_chan_q;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count_q      <= 2'd0;
            rr_ptr_q     <= '0;
            slot0_data_q <= '0;
            slot0_chan_q <= '0;
            slot1_data_q <= '0;
            slot1_chan_q <= '0;
        end else begin
            count_q      <= count_d;
            rr_ptr_q     <= rr_ptr_d;
            slot0_data_q <= slot0_data_d;
            slot0_chan_q <= slot0_chan_d;
            slot1_data_q <= slot1_data_d;
            slot1_chan_q <= slot1_chan_d;
        end
    end

    assign bus.oData  = slot0_data_q;
    assign bus.oChan  = slot0_chan_q;
    assign bus.oValid = (count_q != 2'd0);

endmodule

// File: tb/tb_mux_n_stream.sv
// Bench for mux_n_stream: directed scenarios plus random traffic, all checked
// against a queue-based model of the merged stream.
module tb_mux_n_stream;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    mux_n_stream_if #(.DATA_WIDTH(32), .NUM_CH(4), .SEL_WIDTH(2)) bus();
    mux_n_stream #(.DATA_WIDTH(32), .NUM_CH(4), .SEL_WIDTH(2)) dut (
        .clk(clk), .resetn(resetn), .bus(bus)
    );

    // Five channels so an out-of-range select (5) is representable.
    mux_n_stream_if #(.DATA_WIDTH(8), .NUM_CH(5), .SEL_WIDTH(3)) bus5();
    mux_n_stream #(.DATA_WIDTH(8), .NUM_CH(5), .SEL_WIDTH(3)) dut5 (
        .clk(clk), .resetn(resetn), .bus(bus5)
    );

    typedef struct {
        logic [31:0] d;
        int          c;
    } ent_t;

    ent_t        mq[$];
    ent_t        last_head;
    int          rr;
    int          total = 0;
    int          bad = 0;
    bit          acc_flag;
    logic [31:0] out_d[$];
    int          out_c[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int exp_grant();
        if (!bus.iMode) begin
            return bus.iValid[int'(bus.iSel)] ? int'(bus.iSel) : -1;
        end
        for (int i = 0; i < 4; i++) begin
            if (bus.iValid[(rr + i) % 4]) return (rr + i) % 4;
        end
        return -1;
    endfunction

    // One clock cycle: check outputs before the edge, then advance the model.
    task automatic cyc();
        int   g;
        bit   sp;
        bit   drn;
        ent_t e;
        logic [3:0] exp_rdy;
        @(negedge clk);
        g  = exp_grant();
        sp = (mq.size() < 2);
        exp_rdy = (g >= 0 && sp) ? (4'b0001 << g) : 4'b0000;
        chk("oReady", bus.oReady, exp_rdy);
        chk("oValid", bus.oValid, mq.size() != 0);
        if (mq.size() != 0) last_head = mq[0];
        chk("oData", bus.oData, last_head.d);
        chk("oChan", bus.oChan, last_head.c);
        chk("oReady_oob", bus5.oReady, 0);
        chk("oValid_oob", bus5.oValid, 0);
        if (bus.oValid && bus.iReady) begin
            out_d.push_back(bus.oData);
            out_c.push_back(int'(bus.oChan));
        end
        acc_flag = (g >= 0 && sp);
        drn = (mq.size() != 0) && bus.iReady;
        if (drn) void'(mq.pop_front());
        if (acc_flag) begin
            e.d = bus.iData[g*32 +: 32];
            e.c = g;
            mq.push_back(e);
            if (bus.iMode) rr = (g + 1) % 4;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain_all();
        bus.iValid = 4'b0000;
        bus.iReady = 1'b1;
        cyc();
        cyc();
    endtask

    task automatic rand_data();
        bus.iData = {$urandom, $urandom, $urandom, $urandom};
    endtask

    initial begin
        int          w;
        int          rr_seq[6];
        logic [31:0] first_d;

        rr_seq = '{0, 1, 2, 3, 0, 1};
        rr = 0;
        last_head.d = '0;
        last_head.c = 0;

        resetn     = 1'b0;
        bus.iData  = '0;
        bus.iValid = 4'b1111;
        bus.iMode  = 1'b1;
        bus.iSel   = 2'd0;
        bus.iReady = 1'b1;
        bus5.iData  = 40'h0102030405;
        bus5.iValid = 5'b11111;
        bus5.iMode  = 1'b0;
        bus5.iSel   = 3'd5;
        bus5.iReady = 1'b1;

        #1;
        chk("rst_oValid", bus.oValid, 0);
        chk("rst_oData", bus.oData, 0);
        chk("rst_oChan", bus.oChan, 0);
        chk("rst_oReady", bus.oReady, 0);
        @(negedge clk);
        bus.iValid = 4'b0000;
        resetn = 1'b1;
        @(posedge clk);
        #1;

        // Fixed mode, channel 2 selected, every channel offering a word.
        bus.iData  = {32'h1003, 32'h1002, 32'h1001, 32'h1000};
        bus.iMode  = 1'b0;
        bus.iSel   = 2'd2;
        bus.iValid = 4'b1111;
        bus.iReady = 1'b1;
        cyc();
        for (int i = 0; i < 4; i++) begin
            chk("fix_oData", bus.oData, 32'h1002);
            chk("fix_oChan", bus.oChan, 2);
            chk("fix_oReady", bus.oReady, 4'b0100);
            cyc();
        end

        // Round-robin, all channels valid: pointer starts at 0.
        drain_all();
        out_d.delete();
        out_c.delete();
        bus.iMode  = 1'b1;
        bus.iValid = 4'b1111;
        for (int i = 0; i < 7; i++) begin
            rand_data();
            cyc();
        end
        chk("rr_len", out_c.size(), 6);
        for (int i = 0; i < 6 && i < out_c.size(); i++) chk("rr_seq", out_c[i], rr_seq[i]);

        // Round-robin, only channels 1 and 3 valid.
        drain_all();
        out_d.delete();
        out_c.delete();
        bus.iValid = 4'b1010;
        for (int i = 0; i < 8; i++) begin
            rand_data();
            cyc();
        end
        chk("rr13_len", out_c.size(), 7);
        for (int i = 0; i < out_c.size(); i++) begin
            chk("rr13_idle", (out_c[i] == 1 || out_c[i] == 3), 1);
            if (i > 0) chk("rr13_alt", (out_c[i] != out_c[i-1]), 1);
        end

        // Backpressure: ch0 words 1..4, sink stalled for three cycles.
        drain_all();
        out_d.delete();
        out_c.delete();
        bus.iMode = 1'b0;
        bus.iSel  = 2'd0;
        w = 1;
        for (int i = 0; i < 12; i++) begin
            bus.iValid = (w <= 4) ? 4'b0001 : 4'b0000;
            bus.iData  = {96'h0, 32'(w)};
            bus.iReady = (i >= 3);
            cyc();
            if (acc_flag) w++;
            if (i == 2) begin
                chk("bp_full_ready", bus.oReady[0], 0);
                chk("bp_hold_data", bus.oData, 1);
            end
        end
        chk("bp_len", out_d.size(), 4);
        for (int i = 0; i < 4 && i < out_d.size(); i++) chk("bp_order", out_d[i], i + 1);

        // Random traffic against the model.
        for (int i = 0; i < 300; i++) begin
            rand_data();
            bus.iMode  = $urandom_range(0, 1) == 1;
            bus.iSel   = 2'($urandom_range(0, 3));
            bus.iValid = 4'($urandom_range(0, 15));
            bus.iReady = $urandom_range(0, 3) != 0;
            cyc();
        end

        // Reset with the buffer full.
        bus.iMode  = 1'b1;
        bus.iValid = 4'b1111;
        bus.iReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rand_data();
            cyc();
        end
        chk("pre_rst_full", bus.oReady, 0);
        #2;
        resetn = 1'b0;
        #1;
        chk("mid_rst_oValid", bus.oValid, 0);
        chk("mid_rst_oData", bus.oData, 0);
        chk("mid_rst_oChan", bus.oChan, 0);
        chk("mid_rst_oReady", bus.oReady, 0);
        mq.delete();
        rr = 0;
        last_head.d = '0;
        last_head.c = 0;
        @(negedge clk);
        bus.iValid = 4'b0000;
        resetn = 1'b1;
        @(posedge clk);
        #1;
        out_d.delete();
        out_c.delete();
        bus.iValid = 4'b1111;
        bus.iReady = 1'b1;
        rand_data();
        first_d = bus.iData[31:0];
        cyc();
        for (int i = 0; i < 3; i++) begin
            rand_data();
            cyc();
        end
        chk("post_rst_len", out_c.size(), 3);
        if (out_c.size() > 0) begin
            chk("post_rst_chan", out_c[0], 0);
            chk("post_rst_data", out_d[0], first_d);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
